timer_array: RTL

Parametrised multi-channel down-counting timer with an on-block register decoder and per-channel interrupt lines. It is the next-generation replacement for the fixed pair of counters behind the system bridge. The CPU reaches it through the bridge's device port, and its `irq` vector drives the CPU hardware-interrupt inputs. It adds one-shot and auto-reload modes, per-channel interrupt masking, write-1-to-clear status and an optional prescaler.

---
 rtl/timer_pkg.sv | 47 ++++
 rtl/timer_channel.sv | 172 +++++++++++++++++
 rtl/timer_array.sv | 94 +++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// ============================================================================
// timer_pkg
// Shared definitions for the timer_array block: register word offsets inside
// a channel window, CTRL field positions, MODE encodings and a helper that
// assembles the CTRL read value.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  // Word offsets within one 16-byte channel window (addr[3:2])
  typedef enum logic [1:0] {
    WORD_CTRL   = 2'd0,
    WORD_PRESET = 2'd1,
    WORD_COUNT  = 2'd2,
    WORD_STATUS = 2'd3
  } word_e;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;
  localparam int CTRL_PS_LSB   = 8;
  localparam int PS_W          = 8;

  // MODE encodings; 2'b1x behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Assemble the CTRL read word; unlisted bits read as zero
  function automatic logic [31:0] pack_ctrl(input logic       en,
                                            input logic [1:0] mode,
                                            input logic       im,
                                            input logic [7:0] ps);
    logic [31:0] v;
    v                          = '0;
    v[CTRL_EN_BIT]             = en;
    v[CTRL_MODE_LSB +: 2]      = mode;
    v[CTRL_IM_BIT]             = im;
    v[CTRL_PS_LSB +: PS_W]     = ps;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/timer_channel.sv
// ============================================================================
// timer_channel
// One down-counting timer channel: CTRL/PRESET/COUNT registers, one-shot and
// auto-reload expiry, write-1-to-clear pend flag and masked interrupt.
// Optional feature macro: TIMER_PRESCALE_EN (8-bit prescaler from CTRL.PS).
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   wr_ctrl_i         write strobe for CTRL
//   wr_preset_i       write strobe for PRESET
//   wr_status_i       write strobe for STATUS (bit0 W1C)
//   wdata_i[31:0]     write data
//   ctrl_o/preset_o/count_o  read values (zero-extended)
//   pend_o            pending flag
//   irq_o             registered interrupt, pend & IM
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_ctrl_i,
  input  logic              wr_preset_i,
  input  logic              wr_status_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       ctrl_o,
  output logic [31:0]       preset_o,
  output logic [31:0]       count_o,
  output logic              pend_o,
  output logic              irq_o
);

  logic             en_q,     en_d;
  logic [1:0]       mode_q,   mode_d;
  logic             im_q,     im_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             pend_q,   pend_d;

  logic w_ps_hit;
  logic w_tick;
  logic w_stop;
  logic w_expire;
  logic w_unused;

`ifdef TIMER_PRESCALE_EN
  logic [PS_W-1:0] ps_q,  ps_d;
  logic [PS_W-1:0] psc_q, psc_d;

  // psc_q counts enabled cycles since the last tick/load; tick on reaching PS
  assign w_ps_hit = (psc_q == ps_q);
`else
  assign w_ps_hit = 1'b1;
`endif

  assign w_tick   = en_q && (count_q != '0) && w_ps_hit;
  // A software EN=0 on this edge freezes COUNT, so the expiry never happens
  assign w_stop   = wr_ctrl_i && !wdata_i[CTRL_EN_BIT];
  assign w_expire = w_tick && (count_q == CNT_W'(1)) && !w_stop;

  assign w_unused = ^wdata_i;

  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;
`ifdef TIMER_PRESCALE_EN
    ps_d     = ps_q;
    psc_d    = psc_q;
`endif

    // Hardware progression; a load with PRESET=0 stops on the following edge
    if (en_q && (count_q == '0)) begin
      en_d = 1'b0;
    end
    if (w_tick && !w_stop) begin
      if (count_q == CNT_W'(1)) begin
        if (mode_q == MODE_RELOAD) begin
          count_d = preset_q;
        end else begin
          count_d = '0;
          en_d    = 1'b0;
        end
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end

`ifdef TIMER_PRESCALE_EN
    if (!en_q || w_tick) begin
      psc_d = '0;
    end else begin
      psc_d = psc_q + 8'd1;
    end
`endif

    if (wr_preset_i) begin
      preset_d = wdata_i[CNT_W-1:0];
    end

    // Software CTRL write overrides the hardware EN update on the same edge
    if (wr_ctrl_i) begin
      en_d   = wdata_i[CTRL_EN_BIT];
      mode_d = wdata_i[CTRL_MODE_LSB +: 2];
      im_d   = wdata_i[CTRL_IM_BIT];
`ifdef TIMER_PRESCALE_EN
      ps_d   = wdata_i[CTRL_PS_LSB +: PS_W];
`endif
      if (wdata_i[CTRL_EN_BIT] && !en_q) begin
        count_d = preset_q;
`ifdef TIMER_PRESCALE_EN
        psc_d   = '0;
`endif
      end
    end

    // Hardware set has priority over W1C
    if (wr_status_i && wdata_i[0]) begin
      pend_d = 1'b0;
    end
    if (w_expire) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      ps_q     <= '0;
      psc_q    <= '0;
`endif
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
`ifdef TIMER_PRESCALE_EN
      ps_q     <= ps_d;
      psc_q    <= psc_d;
`endif
    end
  end

`ifdef TIMER_PRESCALE_EN
  assign ctrl_o = pack_ctrl(en_q, mode_q, im_q, ps_q);
`else
  assign ctrl_o = pack_ctrl(en_q, mode_q, im_q, 8'h00);
`endif
  assign preset_o = 32'(preset_q);
  assign count_o  = 32'(count_q);
  assign pend_o   = pend_q;
  assign irq_o    = pend_q & im_q;

endmodule

`default_nettype wire

// File: rtl/timer_array.sv
// ============================================================================
// timer_array
// Parametrised multi-channel down-counting timer with register decoder and
// per-channel interrupt lines. Each channel occupies a 16-byte window:
// CTRL (0x0), PRESET (0x4), COUNT (0x8, RO), STATUS (0xC, bit0 W1C).
// Optional feature macro: TIMER_PRESCALE_EN (per-channel 8-bit prescaler).
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   we              write strobe
//   addr[ADDR_W-1:0] byte offset; [ADDR_W-1:4] channel, [3:2] word
//   wdata[31:0]     write data
//   rdata[31:0]     combinational read data
//   irq[N_CH-1:0]   per-channel interrupt
//   irq_any         OR of irq
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_array
  import timer_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [N_CH-1:0]   irq,
  output logic              irq_any
);

  localparam int SEL_W = ADDR_W - 4;

  logic [SEL_W-1:0]       w_sel;
  word_e                  w_word;
  logic [N_CH-1:0][31:0]  w_ctrl;
  logic [N_CH-1:0][31:0]  w_preset;
  logic [N_CH-1:0][31:0]  w_count;
  logic [N_CH-1:0]        w_pend;
  logic                   w_unused;

  assign w_sel    = addr[ADDR_W-1:4];
  assign w_word   = word_e'(addr[3:2]);
  assign w_unused = ^addr[1:0];

  // Channel selects beyond N_CH match no instance, so those writes vanish
  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic w_hit;
      assign w_hit = we && (w_sel == SEL_W'(g));

      timer_channel #(
        .CNT_W (CNT_W)
      ) u_ch (
        .clk         (clk),
        .reset       (reset),
        .wr_ctrl_i   (w_hit && (w_word == WORD_CTRL)),
        .wr_preset_i (w_hit && (w_word == WORD_PRESET)),
        .wr_status_i (w_hit && (w_word == WORD_STATUS)),
        .wdata_i     (wdata),
        .ctrl_o      (w_ctrl[g]),
        .preset_o    (w_preset[g]),
        .count_o     (w_count[g]),
        .pend_o      (w_pend[g]),
        .irq_o       (irq[g])
      );
    end
  endgenerate

  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_sel == SEL_W'(i)) begin
        case (w_word)
          WORD_CTRL:   rdata = w_ctrl[i];
          WORD_PRESET: rdata = w_preset[i];
          WORD_COUNT:  rdata = w_count[i];
          WORD_STATUS: rdata = {31'b0, w_pend[i]};
          default:     rdata = '0;
        endcase
      end
    end
  end

  assign irq_any = |irq;

endmodule

`default_nettype wire
